// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC owner and fetch initiator for a zero-latency instruction ROM.
//               Fetched words are buffered in a small FIFO and handed to decode
//               as {pc, instr, fault}. A redirect flushes everything in flight.
//               Optional macro FETCH_STATS_EN adds retired/flushed counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_WORDS = 128,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_retired,
    output logic [31:0] stat_flushed,
`endif
    output logic        out_fault
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam int            IW         = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [32:0]   c_PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_fault_stop;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic          r_fault_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_oob;
    logic [IW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_nxt;

    assign w_pop       = r_valid & out_ready;
    assign w_push      = fetch_en & ~r_fault_stop & ~redirect_valid &
                         ((r_count < c_DEPTH) | w_pop);
    assign w_oob       = ({1'b0, r_pc} >= c_PC_LIMIT);
    // Slot 0 is always the head; a simultaneous pop shifts the tail down one.
    assign w_wr_idx    = IW'(r_count - CW'(w_pop));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign imem_addr = r_pc;
    assign out_valid = r_valid;
    assign out_pc    = r_pc_mem[0];
    assign out_instr = r_instr_mem[0];
    assign out_fault = r_fault_mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_fault_stop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
                r_fault_mem[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Redirect wins over any pop offered this cycle.
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_fault_stop <= 1'b0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_pc_mem[i]    <= r_pc_mem[i+1];
                    r_instr_mem[i] <= r_instr_mem[i+1];
                    r_fault_mem[i] <= r_fault_mem[i+1];
                end
            end
            if (w_push) begin
                r_pc_mem[w_wr_idx] <= r_pc;
                if (w_oob) begin
                    r_instr_mem[w_wr_idx] <= 32'd0;
                    r_fault_mem[w_wr_idx] <= 1'b1;
                    r_fault_stop          <= 1'b1;
                end else begin
                    r_instr_mem[w_wr_idx] <= imem_data;
                    r_fault_mem[w_wr_idx] <= 1'b0;
                    r_pc                  <= r_pc + 32'd4;
                end
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_retired;
    logic [31:0] r_stat_flushed;
    logic [32:0] w_flushed_sum;

    assign w_flushed_sum = {1'b0, r_stat_flushed} + 33'(r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_retired <= '0;
            r_stat_flushed <= '0;
        end else if (redirect_valid) begin
            r_stat_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
        end else if (w_pop && (r_stat_retired != 32'hFFFF_FFFF)) begin
            r_stat_retired <= r_stat_retired + 32'd1;
        end
    end

    assign stat_retired = r_stat_retired;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed plus randomized bench for instr_fetch against a
//               transaction-level queue model of the fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC   = 32'd0;
    localparam int          IMEM_WORDS = 128;
    localparam int          DEPTH      = 2;
    localparam int          AW         = $clog2(IMEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_retired;
    logic [31:0] stat_flushed;
`endif

    logic [31:0] rom [IMEM_WORDS];

    entry_t      q[$];
    logic [31:0] m_pc;
    bit          m_stop;
    longint      m_retired;
    longint      m_flushed;

    int n_checks;
    int n_fail;

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef FETCH_STATS_EN
        .stat_retired   (stat_retired),
        .stat_flushed   (stat_flushed),
`endif
        .out_fault      (out_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Zero-latency ROM; out-of-range reads return junk the DUT must not pass on.
    always_comb begin
        if (imem_addr < 32'(4 * IMEM_WORDS))
            imem_data = rom[imem_addr[AW+1:2]];
        else
            imem_data = 32'hBAD0_0000 ^ imem_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc      = RESET_PC;
        m_stop    = 1'b0;
        m_retired = 0;
        m_flushed = 0;
    endtask

    // One clock edge of the fetch unit, expressed as queue operations.
    task automatic model_edge();
        bit     pop;
        bit     push;
        entry_t e;
        pop = (q.size() != 0) && out_ready;
        if (redirect_valid) begin
            m_flushed += q.size();
            q.delete();
            m_pc   = redirect_pc & ~32'd3;
            m_stop = 1'b0;
        end else begin
            push = fetch_en && !m_stop && ((q.size() < DEPTH) || pop);
            if (pop) begin
                void'(q.pop_front());
                m_retired++;
            end
            if (push) begin
                e.pc = m_pc;
                if (longint'(m_pc) >= longint'(4 * IMEM_WORDS)) begin
                    e.instr = 32'd0;
                    e.fault = 1'b1;
                    m_stop  = 1'b1;
                end else begin
                    e.instr = rom[m_pc >> 2];
                    e.fault = 1'b0;
                    m_pc    = m_pc + 32'd4;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check_eq("out_pc", out_pc, q[0].pc);
            check_eq("out_instr", out_instr, q[0].instr);
            check_eq("out_fault", {31'd0, out_fault}, {31'd0, q[0].fault});
        end
`ifdef FETCH_STATS_EN
        check_eq("stat_retired", stat_retired, sat32(m_retired));
        check_eq("stat_flushed", stat_flushed, sat32(m_flushed));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_addr"}, imem_addr, RESET_PC);
        check_eq({tag, "_pc"}, out_pc, 32'd0);
        check_eq({tag, "_instr"}, out_instr, 32'd0);
        check_eq({tag, "_fault"}, {31'd0, out_fault}, 32'd0);
`ifdef FETCH_STATS_EN
        check_eq({tag, "_retired"}, stat_retired, 32'd0);
        check_eq({tag, "_flushed"}, stat_flushed, 32'd0);
`endif
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        for (int i = 0; i < IMEM_WORDS; i++) rom[i] = $urandom;
        model_reset();

        #12;
        rst_n = 1'b1;
        #1;
        check_reset_state("reset");

        // Streaming from reset with decode always ready.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        repeat (6) step();

        // Backpressure then release.
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect to an unaligned target while two entries are buffered.
        out_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd83;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();

        // Run off the end of the ROM, then restart at 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd508;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();

        // Freeze fetch with a full buffer and let it drain.
        out_ready = 1'b0;
        repeat (3) step();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic with one asynchronous reset mid-stream.
        for (int c = 0; c < 600; c++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 600);
            if (c == 300) async_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-side initiator for the combinational instruction memory: owns the PC, drives the word address, captures returned instruction words.
- Buffers fetched words in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (jump/branch/exception targets) from execute; a redirect flushes all in-flight words.
- Sits between the program ROM (pc in, id out, zero-latency read) and the decode stage.

Parameters:
RESET_PC, 32'd0, PC loaded on reset (program-selector entry).
IMEM_WORDS, 128, number of instruction words in the ROM; valid byte addresses are 0 .. 4*IMEM_WORDS-4.
DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
fetch_en  in  1  1 = fetch allowed; 0 = freeze PC (FIFO still drains).
imem_addr  out  32  byte address to ROM; always equals pc_q.
imem_data  in  32  instruction word from ROM, valid in the same cycle as imem_addr.
redirect_valid  in  1  load new PC and flush.
redirect_pc  in  32  target; bits [1:0] ignored (forced 0).
out_valid  out  1  FIFO head valid.
out_ready  in  1  decode accepts head.
out_pc  out  32  PC of head entry.
out_instr  out  32  instruction of head entry.
out_fault  out  1  head entry is an out-of-range fetch; out_instr = 0.

Behaviour:
- Reset, asynchronous: pc_q = RESET_PC, FIFO count = 0, fault_stop = 0, out_valid = 0; out_pc, out_instr, out_fault = 0.
- pop = out_valid & out_ready.
- push = fetch_en & ~fault_stop & ~redirect_valid & (count < DEPTH | pop).
- On push:
  - entry {pc_q, imem_data, fault=0} is written at the tail; pc_q += 4.
  - If pc_q >= 4*IMEM_WORDS, the entry is {pc_q, 32'd0, fault=1}, pc_q is held, and fault_stop is set.
- fault_stop clears only on redirect or reset.
- PC arithmetic is 32-bit and wraps at 2^32. The range check fires first, so 2^32 is reached only when IMEM_WORDS is huge.
- Redirect has priority over push and pop in the same cycle. At the edge: FIFO count = 0, pc_q = {redirect_pc[31:2], 2'b00}, fault_stop = 0.
  - The head offered in the redirect cycle is treated as not accepted, even if out_ready = 1.
  - Decode must not act on it.
- Latency:
  - Redirect asserted in cycle t: imem_addr = target in t+1; out_valid with out_pc = target in t+2.
  - From reset release: first entry valid one cycle after the first edge with fetch_en = 1.
- Throughput: one entry per cycle with out_ready held high. Full FIFO plus pop in the same cycle pushes and pops together; count is unchanged.
- Stall: when count == DEPTH and no pop, pc_q and imem_addr hold steady. No word is dropped or duplicated.
- Head outputs are registered from FIFO storage and remain stable while out_valid & ~out_ready.
- fetch_en = 0 does not flush; buffered entries still drain.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs stat_retired (32-bit, increments on each pop without redirect) and stat_flushed (32-bit, adds the FIFO count discarded by each redirect).
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, fetch_en=1, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; out_instr equals ROM words 0..3.
- Hold out_ready=0 for 5 cycles after reset (DEPTH=2) -> count saturates at 2, imem_addr holds at 8; release -> out_pc 0,4,8 with no gaps or duplicates.
- With 2 entries buffered, pulse redirect_valid with redirect_pc=32'd83 while out_ready=1 -> no pop that cycle, FIFO emptied, imem_addr=80 at t+1, out_pc=80 at t+2.
- redirect_pc=508, IMEM_WORDS=128 -> entries pc 508 (fault=0), then pc 512 (fault=1, instr=0); imem_addr stuck at 512; no further pushes until a redirect to 0 restarts at pc 0.
- fetch_en=0 with 2 entries buffered -> both drain with out_ready=1; imem_addr unchanged; out_valid=0 afterwards.
- Assert rst_n low mid-stream (async, between edges) -> out_valid=0 and imem_addr=RESET_PC immediately; with FETCH_STATS_EN, both stat counters read 0.
